// File: rtl/gf180mcu_clkdiv_gate.sv
// ---------------------------------------------------------------------------
// gf180mcu_clkdiv_gate
//
// Programmable integer clock divider with glitch-free start/stop. Z is the
// source clock for the downstream clock buffer tree. Every output comes
// straight from a CLK flop, so no combinational path from CLK reaches Z.
// A new ratio is picked up only when one period ends and the next begins,
// so Z never produces a runt pulse. The one exception is RST, which forces
// Z low immediately.
//
// Divide ratio N = DIV+1, giving 2..2^WIDTH. DIV=0 is treated as N=2.
// Z is high for floor(N/2) cycles and low for the rest of the period.
//
// Ports:
//   CLK   in   1      source clock, rising-edge state updates
//   RST   in   1      asynchronous active-high reset
//   EN    in   1      run request, sampled on CLK
//   DIV   in   WIDTH  ratio code (N = DIV+1)
//   Z     out  1      divided clock
//   BUSY  out  1      high while running
//   TICK  out  1      one-CLK pulse on the first source cycle of each period
//
// Optional feature macro: GF180_CLKDIV_DUTY50_EN
//   When defined, a falling-edge flop stretches Z half a CLK period into the
//   low phase for odd ratios, which gives an exact 50% duty cycle. Even
//   ratios, TICK and BUSY are unaffected.
// ---------------------------------------------------------------------------
module gf180mcu_clkdiv_gate #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  output logic             Z,
  output logic             BUSY,
  output logic             TICK
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] TWO = {{(WIDTH-1){1'b0}}, 2'b10};

  state_e           state_q;
  logic [WIDTH-1:0] cnt_q;
  // The shadow ratio needs one extra bit so that N = 2^WIDTH fits.
  logic [WIDTH:0]   nSh_q;
  logic             z_q;
  logic             busy_q;
  logic             tick_q;

  logic [WIDTH:0]   cntInc;
  logic [WIDTH:0]   halfN;
  logic [WIDTH:0]   nReq;
  logic             lastCount;

  // cnt is widened to WIDTH+1 bits before the increment. At N = 2^WIDTH the
  // counter then reaches its all-ones code with no wrap-around in the compare.
  always_comb begin
    cntInc    = {1'b0, cnt_q} + ONE;
    halfN     = nSh_q >> 1;
    nReq      = (DIV == '0) ? TWO : ({1'b0, DIV} + ONE);
    lastCount = ({1'b0, cnt_q} == (nSh_q - ONE));
  end

  // Single FSM flop block with registered outputs. The ratio is sampled only
  // on start and on wrap, so a DIV change mid-period waits for the next period.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nSh_q   <= TWO;
      z_q     <= 1'b0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (EN) begin
            state_q <= RUN;
            nSh_q   <= nReq;
            cnt_q   <= '0;
            z_q     <= 1'b1;
            tick_q  <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            z_q     <= 1'b0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          if (!lastCount) begin
            cnt_q  <= cntInc[WIDTH-1:0];
            z_q    <= (cntInc < halfN);
            tick_q <= 1'b0;
          end else if (EN) begin
            // EN seen on the final low cycle continues straight into a new period.
            cnt_q  <= '0;
            nSh_q  <= nReq;
            z_q    <= 1'b1;
            tick_q <= 1'b1;
          end else begin
            // Stop only at the period boundary, so no phase is ever truncated.
            state_q <= IDLE;
            cnt_q   <= '0;
            z_q     <= 1'b0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign BUSY = busy_q;
  assign TICK = tick_q;

`ifdef GF180_CLKDIV_DUTY50_EN
  // The falling-edge copy of the high phase holds Z for half a cycle past the
  // last high rising-edge cycle. It does this only for odd ratios. Both inputs
  // of the OR are 1 across the z_q falling edge, so Z does not glitch.
  logic zFall_q;

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      zFall_q <= 1'b0;
    end else begin
      zFall_q <= z_q & nSh_q[0];
    end
  end

  assign Z = z_q | zFall_q;
`else
  assign Z = z_q;
`endif

endmodule
